// File: rtl/vector_wb_queue.sv
// Writeback queue behind the 4-lane fp32 ALU: latency-matched tag pipeline, in-order result FIFO, issue credit.
// Optional same-cycle bypass of an empty FIFO is enabled by defining VWB_BYPASS_EN.
module vector_wb_queue #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned REG_W = 5,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [REG_W-1:0] issue_vdst,
  input  logic [3:0]       issue_vmask,
  input  logic             issue_wr_v,
  input  logic [REG_W-1:0] issue_rdst,
  input  logic             issue_wr_r,
  input  logic [127:0]     alu_vout,
  input  logic [31:0]      alu_rout,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [REG_W-1:0] wb_vdst,
  output logic [3:0]       wb_vmask,
  output logic             wb_wr_v,
  output logic [REG_W-1:0] wb_rdst,
  output logic             wb_wr_r,
  output logic [127:0]     wb_vdata,
  output logic [31:0]      wb_rdata,
  output logic [CW-1:0]    count,
  output logic             ovf_err
);

  localparam int unsigned VW = 128;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned SW = $clog2(DEPTH + LAT + 1);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] vdst;
    logic [3:0]       vmask;
    logic             wr_v;
    logic [REG_W-1:0] rdst;
    logic             wr_r;
  } tag_t;

  typedef struct packed {
    logic [REG_W-1:0] vdst;
    logic [3:0]       vmask;
    logic             wr_v;
    logic [REG_W-1:0] rdst;
    logic             wr_r;
    logic [VW-1:0]    vdata;
    logic [31:0]      rdata;
  } entry_t;

  tag_t            tag_q [LAT];
  tag_t            tag_in;
  tag_t            tag_exit;
  entry_t          exit_entry;
  entry_t          head_q;
  entry_t          head_d;
  entry_t          out_entry;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   rd_ptr_d;
  logic [PW-1:0]   rd_inc;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [IW-1:0]   inflight_q;
  logic [IW-1:0]   inflight_d;
  logic            fifo_valid_q;
  logic            ready_q;
  logic            ready_d;
  logic            ovf_q;
  logic            fire;
  logic            exit_wr;
  logic            push;
  logic            pop;
  logic            bypass_take;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fire     = issue_valid && ready_q;
  assign tag_exit = tag_q[LAT-1];
  assign exit_wr  = tag_exit.valid && (tag_exit.wr_v || tag_exit.wr_r);

  // Tag for stage 0 and the result entry formed when the oldest tag meets its ALU data
  always_comb begin
    tag_in             = '0;
    tag_in.valid       = fire;
    tag_in.vdst        = issue_vdst;
    tag_in.vmask       = issue_vmask;
    tag_in.wr_v        = issue_wr_v;
    tag_in.rdst        = issue_rdst;
    tag_in.wr_r        = issue_wr_r;
    exit_entry         = '0;
    exit_entry.vdst    = tag_exit.vdst;
    exit_entry.vmask   = tag_exit.vmask;
    exit_entry.wr_v    = tag_exit.wr_v;
    exit_entry.rdst    = tag_exit.rdst;
    exit_entry.wr_r    = tag_exit.wr_r;
    exit_entry.vdata   = alu_vout;
    exit_entry.rdata   = alu_rout;
  end

`ifdef VWB_BYPASS_EN
  logic bypass_act;
  assign bypass_act  = (count_q == '0) && exit_wr;
  assign bypass_take = bypass_act && wb_ready;
  assign wb_valid    = fifo_valid_q || bypass_act;
  assign out_entry   = bypass_act ? exit_entry : head_q;
`else
  assign bypass_take = 1'b0;
  assign wb_valid    = fifo_valid_q;
  assign out_entry   = head_q;
`endif

  // FIFO bookkeeping, next head entry, and next-cycle credit
  always_comb begin
    push       = exit_wr && !bypass_take;
    pop        = fifo_valid_q && wb_ready;
    rd_inc     = ptr_inc(rd_ptr_q);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_inc : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + IW'(fire) - IW'(tag_exit.valid);
    head_d     = head_q;
    if (push && ((count_q == '0) || (pop && (count_q == CW'(1)))))
      head_d = exit_entry;
    else if (pop && (count_q > CW'(1)))
      head_d = mem_q[rd_inc];
    ready_d = (SW'(count_d) + SW'(inflight_d)) < SW'(DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      fifo_valid_q <= 1'b0;
      head_q       <= '0;
      ready_q      <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      fifo_valid_q <= (count_d != '0);
      head_q       <= head_d;
      ready_q      <= ready_d;
      ovf_q        <= ovf_q || (issue_valid && !ready_q);
    end
  end

  // Storage is not reset; occupancy and pointers alone define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= exit_entry;
  end

  assign issue_ready = ready_q;
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign wb_vdst     = out_entry.vdst;
  assign wb_vmask    = out_entry.vmask;
  assign wb_wr_v     = out_entry.wr_v;
  assign wb_rdst     = out_entry.rdst;
  assign wb_wr_r     = out_entry.wr_r;
  assign wb_vdata    = out_entry.vdata;
  assign wb_rdata    = out_entry.rdata;

endmodule

// File: tb/tb_vector_wb_queue.sv
// Directed bench for vector_wb_queue (LAT=4, DEPTH=8): latency, fill/drain, credit, overflow error, reset.
module tb_vector_wb_queue;

  logic         clk;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic [4:0]   issue_vdst;
  logic [3:0]   issue_vmask;
  logic         issue_wr_v;
  logic [4:0]   issue_rdst;
  logic         issue_wr_r;
  logic [127:0] alu_vout;
  logic [31:0]  alu_rout;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_vdst;
  logic [3:0]   wb_vmask;
  logic         wb_wr_v;
  logic [4:0]   wb_rdst;
  logic         wb_wr_r;
  logic [127:0] wb_vdata;
  logic [31:0]  wb_rdata;
  logic [3:0]   count;
  logic         ovf_err;

  int tests = 0;
  int fails = 0;

  vector_wb_queue dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vdst(issue_vdst), .issue_vmask(issue_vmask), .issue_wr_v(issue_wr_v),
    .issue_rdst(issue_rdst), .issue_wr_r(issue_wr_r),
    .alu_vout(alu_vout), .alu_rout(alu_rout),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_vdst(wb_vdst), .wb_vmask(wb_vmask), .wb_wr_v(wb_wr_v),
    .wb_rdst(wb_rdst), .wb_wr_r(wb_wr_r),
    .wb_vdata(wb_vdata), .wb_rdata(wb_rdata),
    .count(count), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_vdst = '0; issue_vmask = '0; issue_wr_v = 1'b0;
    issue_rdst = '0; issue_wr_r = 1'b0; alu_vout = '0; alu_rout = '0; wb_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_ovf", 128'(ovf_err), 128'(0));
    chk("rst_wb_vdata", wb_vdata, 128'(0));
    chk("rst_wb_vdst", 128'(wb_vdst), 128'(0));
    rst = 1'b0;
    tick();
    chk("rst_ready", 128'(issue_ready), 128'(1));

`ifndef VWB_BYPASS_EN
    // Single op: issue at edge 0, ALU data just before edge 4, wb_valid after edge 4
    issue_valid = 1'b1; issue_vdst = 5'd3; issue_vmask = 4'hF; issue_wr_v = 1'b1; issue_wr_r = 1'b0;
    tick();
    issue_valid = 1'b0;
    tick(); tick(); tick();
    alu_vout = 128'h40800000_40400000_40000000_3F800000;
    alu_rout = 32'hDEADBEEF;
    chk("single_pre_valid", 128'(wb_valid), 128'(0));
    tick();
    alu_vout = '0; alu_rout = '0;
    chk("single_valid", 128'(wb_valid), 128'(1));
    chk("single_count", 128'(count), 128'(1));
    chk("single_vdst", 128'(wb_vdst), 128'(3));
    chk("single_vmask", 128'(wb_vmask), 128'(4'hF));
    chk("single_wr_v", 128'(wb_wr_v), 128'(1));
    chk("single_wr_r", 128'(wb_wr_r), 128'(0));
    chk("single_vdata", wb_vdata, 128'h40800000_40400000_40000000_3F800000);
    chk("single_rdata", 128'(wb_rdata), 128'(32'hDEADBEEF));
    tick();
    chk("single_hold_vdst", 128'(wb_vdst), 128'(3));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("single_pop_count", 128'(count), 128'(0));
    chk("single_pop_valid", 128'(wb_valid), 128'(0));
`endif

    // Fill with backpressure; edge 8 is an illegal issue (ready low)
    wb_ready = 1'b0;
    for (int s = 0; s < 13; s++) begin
      issue_valid = (s < 9); issue_vdst = 5'(s); issue_rdst = 5'(s + 10);
      issue_vmask = 4'hF; issue_wr_v = 1'b1; issue_wr_r = 1'b1;
      if (s >= 4 && s < 12) begin
        alu_vout = {4{32'h1000 + 32'(s - 4)}};
        alu_rout = 32'h2000 + 32'(s - 4);
      end else begin
        alu_vout = {4{32'hBAD0BAD0}};
        alu_rout = 32'hBADBAD00;
      end
      chk($sformatf("fill_ready_pre%0d", s), 128'(issue_ready), 128'(s < 8));
      tick();
      chk($sformatf("fill_count%0d", s), 128'(count), 128'(clampi(s - 3, 8)));
      chk($sformatf("fill_ovf%0d", s), 128'(ovf_err), 128'(s >= 8));
    end
    issue_valid = 1'b0;
    chk("fill_ready_low", 128'(issue_ready), 128'(0));
    chk("fill_wb_valid", 128'(wb_valid), 128'(1));

    // Drain in issue order; no ninth entry
    wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_valid%0d", k), 128'(wb_valid), 128'(1));
      chk($sformatf("drain_vdst%0d", k), 128'(wb_vdst), 128'(k));
      chk($sformatf("drain_rdst%0d", k), 128'(wb_rdst), 128'(k + 10));
      chk($sformatf("drain_vdata%0d", k), wb_vdata, {4{32'h1000 + 32'(k)}});
      chk($sformatf("drain_rdata%0d", k), 128'(wb_rdata), 128'(32'h2000 + 32'(k)));
      tick();
      chk($sformatf("drain_ready%0d", k), 128'(issue_ready), 128'(1));
    end
    chk("drain_empty_valid", 128'(wb_valid), 128'(0));
    chk("drain_empty_count", 128'(count), 128'(0));
    chk("ovf_sticky", 128'(ovf_err), 128'(1));

    // Four writing ops then four non-writing ops; credit returns when the first non-writer exits
    wb_ready = 1'b0; alu_vout = '0; alu_rout = '0;
    for (int s = 0; s < 12; s++) begin
      issue_valid = (s < 8); issue_vdst = 5'(20 + s); issue_rdst = 5'(s);
      issue_wr_v = (s < 4); issue_wr_r = 1'b0; issue_vmask = 4'h5;
      if (s < 8) chk($sformatf("nw_ready_pre%0d", s), 128'(issue_ready), 128'(1));
      tick();
      chk($sformatf("nw_count%0d", s), 128'(count), 128'(clampi(s - 3, 4)));
      chk($sformatf("nw_ready%0d", s), 128'(issue_ready), 128'(s != 7));
    end
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("nw_drain_vdst%0d", k), 128'(wb_vdst), 128'(20 + k));
      tick();
    end
    chk("nw_empty_valid", 128'(wb_valid), 128'(0));
    chk("nw_empty_count", 128'(count), 128'(0));

    // Reset with 3 tags in flight and 2 entries queued
    wb_ready = 1'b0;
    alu_vout = {4{32'hAAAA5555}}; alu_rout = 32'h55555555;
    issue_wr_v = 1'b1; issue_wr_r = 1'b1; issue_vmask = 4'hF;
    for (int s = 0; s < 5; s++) begin
      issue_valid = 1'b1; issue_vdst = 5'(s + 1);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    chk("mid_count_pre", 128'(count), 128'(2));
    #1 rst = 1'b1;
    #1;
    chk("mid_wb_valid", 128'(wb_valid), 128'(0));
    chk("mid_count", 128'(count), 128'(0));
    chk("mid_wb_vdst", 128'(wb_vdst), 128'(0));
    chk("mid_wb_vdata", wb_vdata, 128'(0));
    chk("mid_wb_rdata", 128'(wb_rdata), 128'(0));
    chk("mid_ovf", 128'(ovf_err), 128'(0));
    tick();
    rst = 1'b0;
    wb_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("post_rst_valid%0d", s), 128'(wb_valid), 128'(0));
      chk($sformatf("post_rst_ready%0d", s), 128'(issue_ready), 128'(1));
      tick();
    end
    chk("post_rst_count", 128'(count), 128'(0));

`ifdef VWB_BYPASS_EN
    // Bypass: empty FIFO and wb_ready high, result consumed in cycle t+LAT without queuing
    alu_vout = '0; alu_rout = '0;
    issue_valid = 1'b1; issue_vdst = 5'd7; issue_wr_v = 1'b1; issue_wr_r = 1'b0;
    tick();
    issue_valid = 1'b0;
    tick(); tick(); tick();
    alu_vout = 128'h11111111_22222222_33333333_44444444;
    #1;
    chk("byp_valid", 128'(wb_valid), 128'(1));
    chk("byp_vdata", wb_vdata, 128'h11111111_22222222_33333333_44444444);
    chk("byp_vdst", 128'(wb_vdst), 128'(7));
    chk("byp_count", 128'(count), 128'(0));
    tick();
    alu_vout = '0;
    chk("byp_count_after", 128'(count), 128'(0));
    chk("byp_valid_after", 128'(wb_valid), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
